inv_mix_columns_seq: RTL and testbench

Decryption-round stage directly downstream of the InvSubBytes stage. It captures the 128-bit round state and XORs it with the round key (AddRoundKey). It then applies InvMixColumns serially, one 32-bit column per clock, and presents the result as a registered 128-bit word with a one-cycle valid pulse. For the final round, the mix is bypassed and only the key addition is applied.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/inv_mix_columns_seq_if.sv | 23 ++
 rtl/inv_mix_column.sv | 20 ++
 rtl/inv_mix_columns_seq.sv | 149 ++++++++++++++
 tb/tb_inv_mix_columns_seq.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES widths, GF(2^8) constants and helpers, and the column-stage FSM encoding.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] GF_E    = 8'h0E;
  localparam logic [BYTE_W-1:0] GF_B    = 8'h0B;
  localparam logic [BYTE_W-1:0] GF_D    = 8'h0D;
  localparam logic [BYTE_W-1:0] GF_9    = 8'h09;
  localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; constant k lets synthesis fold this to a few XORs.
  function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] a,
                                             input logic [BYTE_W-1:0] k);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < BYTE_W; i++) begin
      if (k[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Request/result bundle between the InvSubBytes stage and the InvMixColumns stage.
interface inv_mix_columns_seq_if;
  import aes_pkg::*;

  logic [STATE_W-1:0] state_in;
  logic [STATE_W-1:0] round_key;
  logic               last_round;
  logic               InvMixColEN;
  logic               InvMixColBusy;
  logic               InvMixColValid;
  logic [STATE_W-1:0] InvMixCol_Out;

  modport master (
    output state_in, round_key, last_round, InvMixColEN,
    input  InvMixColBusy, InvMixColValid, InvMixCol_Out
  );

  modport slave (
    input  state_in, round_key, last_round, InvMixColEN,
    output InvMixColBusy, InvMixColValid, InvMixCol_Out
  );

endinterface

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit column; row 0 is the most significant byte.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_in;

  assign col_out = {
    gmul(a0, GF_E) ^ gmul(a1, GF_B) ^ gmul(a2, GF_D) ^ gmul(a3, GF_9),
    gmul(a1, GF_E) ^ gmul(a2, GF_B) ^ gmul(a3, GF_D) ^ gmul(a0, GF_9),
    gmul(a2, GF_E) ^ gmul(a3, GF_B) ^ gmul(a0, GF_D) ^ gmul(a1, GF_9),
    gmul(a3, GF_E) ^ gmul(a0, GF_B) ^ gmul(a1, GF_D) ^ gmul(a2, GF_9)
  };

endmodule

// File: rtl/inv_mix_columns_seq.sv
// AddRoundKey followed by column-serial InvMixColumns (bypassed on the last round).
// Define INVMIXCOL_ONECYCLE_EN to transform all four columns at the capture edge.
//
// state | meaning
// IDLE  | waiting for InvMixColEN; result register holds last completion
// MIX   | transforming column col_cnt of work, one column per clock
// DONE  | work is final; completes and returns to IDLE at the next edge
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int ADD_KEY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_mix_columns_seq_if.slave bus
);

  state_t             state, next_state;
  logic [STATE_W-1:0] work, work_nxt;
  logic [STATE_W-1:0] out_q;
  logic               valid_q;
  logic               complete;
  logic [STATE_W-1:0] captured;

  assign captured = bus.state_in ^ ((ADD_KEY != 0) ? bus.round_key : '0);

`ifdef INVMIXCOL_ONECYCLE_EN

  logic [STATE_W-1:0] mixed_all;

  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_column u_col (
      .col_in  (captured[STATE_W-1-COL_W*c -: COL_W]),
      .col_out (mixed_all[STATE_W-1-COL_W*c -: COL_W])
    );
  end

  always_comb begin
    next_state = state;
    work_nxt   = work;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.InvMixColEN) begin
          work_nxt   = bus.last_round ? captured : mixed_all;
          next_state = DONE;
        end
      end
      DONE: begin
        complete   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      work    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= next_state;
      work    <= work_nxt;
      valid_q <= complete;
      if (complete) out_q <= work_nxt;
    end
  end

  assign bus.InvMixColBusy = 1'b0;

`else

  logic [1:0]         col_cnt, col_cnt_nxt;
  logic [COL_W-1:0]   col_in, col_out;
  logic [STATE_W-1:0] work_mixed;

  inv_mix_column u_col (
    .col_in  (col_in),
    .col_out (col_out)
  );

  always_comb begin
    col_in     = work[127:96];
    work_mixed = work;
    case (col_cnt)
      2'd0: begin col_in = work[127:96]; work_mixed[127:96] = col_out; end
      2'd1: begin col_in = work[95:64];  work_mixed[95:64]  = col_out; end
      2'd2: begin col_in = work[63:32];  work_mixed[63:32]  = col_out; end
      2'd3: begin col_in = work[31:0];   work_mixed[31:0]   = col_out; end
      default: ;
    endcase
  end

  // Completion from MIX passes straight back to IDLE so Busy drops with Valid.
  always_comb begin
    next_state  = state;
    work_nxt    = work;
    col_cnt_nxt = col_cnt;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.InvMixColEN) begin
          work_nxt    = captured;
          col_cnt_nxt = 2'd0;
          next_state  = bus.last_round ? DONE : MIX;
        end
      end
      MIX: begin
        work_nxt    = work_mixed;
        col_cnt_nxt = col_cnt + 2'd1;
        if (col_cnt == 2'd3) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      DONE: begin
        complete   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
      work    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= next_state;
      col_cnt <= col_cnt_nxt;
      work    <= work_nxt;
      valid_q <= complete;
      if (complete) out_q <= work_nxt;
    end
  end

  assign bus.InvMixColBusy = (state != IDLE);

`endif

  assign bus.InvMixColValid = valid_q;
  assign bus.InvMixCol_Out  = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: keyed (ADD_KEY=1) and keyless (ADD_KEY=0) instances.
module tb_inv_mix_columns_seq;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] R1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] K2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] R2 = 128'h00102030_40506070_8090a0b0_c0d0e0f0;
  localparam logic [127:0] VX = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  inv_mix_columns_seq_if bus_k ();
  inv_mix_columns_seq_if bus_n ();

  // The keyless instance sees the same traffic but an all-ones key that it must ignore.
  assign bus_n.state_in    = bus_k.state_in;
  assign bus_n.round_key   = '1;
  assign bus_n.last_round  = bus_k.last_round;
  assign bus_n.InvMixColEN = bus_k.InvMixColEN;

  inv_mix_columns_seq #(.ADD_KEY(1)) dut_k (.clk(clk), .rst(rst), .bus(bus_k));
  inv_mix_columns_seq #(.ADD_KEY(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request, scrambles inputs after capture, waits (bounded) for Valid.
  task automatic run_req(input logic [127:0] s, input logic [127:0] k, input logic lr,
                         output int lat, output int busy_n);
    @(negedge clk);
    bus_k.state_in    = s;
    bus_k.round_key   = k;
    bus_k.last_round  = lr;
    bus_k.InvMixColEN = 1'b1;
    @(negedge clk);
    bus_k.InvMixColEN = 1'b0;
    bus_k.state_in    = ~s;
    bus_k.round_key   = ~k;
    bus_k.last_round  = ~lr;
    lat    = 0;
    busy_n = 0;
    while (!bus_k.InvMixColValid && lat < 20) begin
      if (bus_k.InvMixColBusy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, busy_n, pulses, last, bad_period, bad_stable;
    logic [127:0] first_out;

    bus_k.state_in    = '0;
    bus_k.round_key   = '0;
    bus_k.last_round  = 1'b0;
    bus_k.InvMixColEN = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  128'(bus_k.InvMixColBusy),  128'd0);
    chk("reset_valid", 128'(bus_k.InvMixColValid), 128'd0);
    chk("reset_out",   bus_k.InvMixCol_Out,        128'd0);
    rst = 1'b1;

    // 1 + 6: serial mix, zero key; keyless instance with all-ones key must agree
    run_req(V1, '0, 1'b0, lat, busy_n);
    chk("t1_latency",       128'(lat),                   128'd4);
    chk("t1_busy_cycles",   128'(busy_n),                128'd4);
    chk("t1_out",           bus_k.InvMixCol_Out,         R1);
    chk("t1_busy_at_valid", 128'(bus_k.InvMixColBusy),   128'd0);
    chk("t6_nokey_out",     bus_n.InvMixCol_Out,         R1);
    chk("t6_nokey_valid",   128'(bus_n.InvMixColValid),  128'd1);
    @(negedge clk);
    chk("t1_valid_one_cycle", 128'(bus_k.InvMixColValid), 128'd0);
    chk("t1_out_held",        bus_k.InvMixCol_Out,        R1);

    // 2: last round bypass
    run_req(V2, K2, 1'b1, lat, busy_n);
    chk("t2_latency",     128'(lat),            128'd1);
    chk("t2_busy_cycles", 128'(busy_n),         128'd1);
    chk("t2_out",         bus_k.InvMixCol_Out,  R2);
    chk("t2_nokey_out",   bus_n.InvMixCol_Out,  V2);
    @(negedge clk);
    chk("t2_valid_one_cycle", 128'(bus_k.InvMixColValid), 128'd0);

    // 3: second request while busy is ignored
    @(negedge clk);
    bus_k.state_in = V1; bus_k.round_key = '0; bus_k.last_round = 1'b0;
    bus_k.InvMixColEN = 1'b1;
    @(negedge clk);
    bus_k.InvMixColEN = 1'b0;
    @(negedge clk);
    bus_k.state_in = VX; bus_k.round_key = K2; bus_k.last_round = 1'b1;
    bus_k.InvMixColEN = 1'b1;
    @(negedge clk);
    bus_k.InvMixColEN = 1'b0;
    pulses = 0;
    first_out = '0;
    for (int c = 0; c < 12; c++) begin
      if (bus_k.InvMixColValid) begin
        if (pulses == 0) first_out = bus_k.InvMixCol_Out;
        pulses++;
      end
      @(negedge clk);
    end
    chk("t3_pulse_count", 128'(pulses), 128'd1);
    chk("t3_out",         first_out,    R1);

    // 4: reset while column 2 is in flight
    @(negedge clk);
    bus_k.state_in = V1; bus_k.round_key = '0; bus_k.last_round = 1'b0;
    bus_k.InvMixColEN = 1'b1;
    @(negedge clk);
    bus_k.InvMixColEN = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_busy",  128'(bus_k.InvMixColBusy),  128'd0);
    chk("t4_valid", 128'(bus_k.InvMixColValid), 128'd0);
    chk("t4_out",   bus_k.InvMixCol_Out,        128'd0);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus_k.InvMixColValid) pulses++;
    end
    chk("t4_no_valid_after_reset", 128'(pulses), 128'd0);
    run_req(V2, K2, 1'b1, lat, busy_n);
    chk("t4_recover_latency", 128'(lat),           128'd1);
    chk("t4_recover_out",     bus_k.InvMixCol_Out, R2);

    // 5: EN held high, back-to-back transforms
    @(negedge clk);
    bus_k.state_in = V1; bus_k.round_key = '0; bus_k.last_round = 1'b0;
    bus_k.InvMixColEN = 1'b1;
    pulses = 0; last = -1; bad_period = 0; bad_stable = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (bus_k.InvMixColValid) begin
        if (last >= 0 && (c - last) != 5) bad_period++;
        last = c;
        pulses++;
      end
      if (pulses == 0 && bus_k.InvMixCol_Out !== R2) bad_stable++;
      if (pulses > 0 && bus_k.InvMixCol_Out !== R1) bad_stable++;
    end
    bus_k.InvMixColEN = 1'b0;
    chk("t5_pulse_count", 128'(pulses),     128'd6);
    chk("t5_period",      128'(bad_period), 128'd0);
    chk("t5_out_stable",  128'(bad_stable), 128'd0);
    repeat (8) @(negedge clk);
    chk("t5_drain_busy", 128'(bus_k.InvMixColBusy), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
